yuv_stream_packer: RTL

Parametrised packer that converts the per-pixel Y/U/V (or raw) dtype stream into fixed-width packed output words for the USB/DDR sink, after the colour pipeline. It generalises the 32-bit YUV packer:
- selectable output word width;
- four packing modes (raw, YUV444, YUV422, Y-only), latched per frame;
- selectable byte order;
- header packing with image-type substitution;
- end-of-frame flush;
- a sticky protocol-error flag.

No line buffer; chroma decimation is horizontal only.

---
 rtl/yuv_stream_packer.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/yuv_stream_packer.sv
// Packs the per-pixel Y/U/V (or raw) beat stream into OUT_WIDTH-bit words,
// with header packing, per-frame config latching and end-of-frame flush.

package yuv_stream_packer_pkg;
    localparam int unsigned DTYPE_WIDTH = 8;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 8'h01;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 8'h02;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START    = 8'h03;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END      = 8'h04;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 8'h05;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 8'h06;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL        = 8'h80;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = 8'h80;

    localparam logic [1:0] MODE_YUV444 = 2'd0;
    localparam logic [1:0] MODE_YUV422 = 2'd1;
    localparam logic [1:0] MODE_YONLY  = 2'd2;

    typedef struct packed {
        logic [DTYPE_WIDTH-1:0] dtype;
        logic [15:0]            meta;
        logic [7:0]             y;
        logic [7:0]             u;
        logic [7:0]             v;
    } beat_t;
endpackage

module yuv_stream_packer
    import yuv_stream_packer_pkg::*;
#(
    parameter int unsigned OUT_WIDTH       = 32,
    parameter int unsigned RAW_PIXEL_SHIFT = 0,
    parameter int unsigned IMAGE_TYPE_IDX  = 0
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic [15:0]            image_type,
    input  logic [1:0]             mode,
    input  logic                   little_endian,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic [15:0]            meta_datai,
    input  logic [7:0]             yi,
    input  logic [7:0]             ui,
    input  logic [7:0]             vi,
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic [OUT_WIDTH-1:0]   datao,
    output logic                   err
);

    localparam int unsigned AW  = OUT_WIDTH + 24;
    localparam int unsigned FW  = $clog2(AW + 1);
    localparam int unsigned HS  = OUT_WIDTH / 16;
    localparam int unsigned HSW = $clog2(HS);

    typedef enum logic [1:0] {ST_STREAM, ST_FLUSH, ST_END} state_e;

    // Stage 1 registers
    logic        r_s1_dv;
    beat_t       r_s1_beat;
    logic [15:0] r_s1_image_type;
    logic [1:0]  r_s1_mode;
    logic        r_s1_le;

    // Stage 2 state
    state_e                 r_state;
    logic [15:0]            r_cfg_image_type;
    logic [1:0]             r_cfg_mode;
    logic                   r_cfg_le;
    logic [AW-1:0]          r_acc;
    logic [FW-1:0]          r_fill;
    logic                   r_phase;
    logic [7:0]             r_u0;
    logic [7:0]             r_v0;
    logic [OUT_WIDTH-1:0]   r_hdr;
    logic [HSW-1:0]         r_hdr_slot;
    logic [15:0]            r_hdr_idx;
    logic                   r_dvo;
    logic [DTYPE_WIDTH-1:0] r_dtypeo;
    logic [OUT_WIDTH-1:0]   r_datao;
    logic                   r_err;

    logic                 w_is_pixel;
    logic                 w_is_hdr;
    logic                 w_raw;
    logic [7:0]           w_raw_byte;
    logic [7:0]           w_u_avg;
    logic [7:0]           w_v_avg;
    logic [23:0]          w_push;
    logic [1:0]           w_nbytes;
    logic [AW-1:0]        w_acc_push;
    logic [FW-1:0]        w_fill_push;
    logic                 w_emit;
    logic [OUT_WIDTH-1:0] w_word;
    logic [OUT_WIDTH-1:0] w_flush_word;
    logic [15:0]          w_hdr_val;
    logic [OUT_WIDTH-1:0] w_hdr_next;
    logic                 w_hdr_done;
    logic                 w_hdr_pending;

    // Reverses byte order so the first-pushed byte lands in bits [7:0].
    function automatic logic [OUT_WIDTH-1:0] f_swap(input logic [OUT_WIDTH-1:0] x);
        logic [OUT_WIDTH-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < OUT_WIDTH / 8; i++) begin
            res[8*i +: 8] = x[OUT_WIDTH-8-8*i +: 8];
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_s1_dv         <= 1'b0;
            r_s1_beat       <= '0;
            r_s1_image_type <= '0;
            r_s1_mode       <= '0;
            r_s1_le         <= 1'b0;
        end else begin
            r_s1_dv         <= dvi;
            r_s1_beat       <= '{dtype: dtypei, meta: meta_datai, y: yi, u: ui, v: vi};
            r_s1_image_type <= image_type;
            r_s1_mode       <= mode;
            r_s1_le         <= little_endian;
        end
    end

    assign w_is_pixel = r_s1_dv && (|(r_s1_beat.dtype & DTYPE_PIXEL_MASK));
    assign w_is_hdr   = r_s1_dv && (r_s1_beat.dtype == DTYPE_HEADER);
    assign w_raw      = (r_cfg_image_type == 16'd0);
    assign w_raw_byte = 8'(r_s1_beat.meta >> RAW_PIXEL_SHIFT);
    assign w_u_avg    = 8'((9'(r_u0) + 9'(r_s1_beat.u)) >> 1);
    assign w_v_avg    = 8'((9'(r_v0) + 9'(r_s1_beat.v)) >> 1);

    // Bytes contributed by this pixel beat, left-aligned (first byte in [23:16]).
    always_comb begin
        w_push   = '0;
        w_nbytes = 2'd1;
        if (w_raw) begin
            w_push = {w_raw_byte, 16'h0000};
        end else begin
            case (r_cfg_mode)
                MODE_YUV444: begin
                    w_push   = {r_s1_beat.y, r_s1_beat.u, r_s1_beat.v};
                    w_nbytes = 2'd3;
                end
                MODE_YUV422: begin
                    if (r_phase) begin
                        w_push   = {r_s1_beat.y, w_u_avg, w_v_avg};
                        w_nbytes = 2'd3;
                    end else begin
                        w_push = {r_s1_beat.y, 16'h0000};
                    end
                end
                default: w_push = {r_s1_beat.y, 16'h0000};
            endcase
        end
    end

    // Accumulator keeps the oldest byte at the MSB; bits below the fill level stay zero.
    assign w_acc_push   = r_acc | ({w_push, {OUT_WIDTH{1'b0}}} >> r_fill);
    assign w_fill_push  = r_fill + FW'({w_nbytes, 3'b000});
    assign w_emit       = (w_fill_push >= FW'(OUT_WIDTH));
    assign w_word       = r_cfg_le ? f_swap(w_acc_push[AW-1 -: OUT_WIDTH])
                                   : w_acc_push[AW-1 -: OUT_WIDTH];
    assign w_flush_word = r_cfg_le ? f_swap(r_acc[AW-1 -: OUT_WIDTH])
                                   : r_acc[AW-1 -: OUT_WIDTH];

    assign w_hdr_val     = (r_hdr_idx == 16'(IMAGE_TYPE_IDX)) ? r_cfg_image_type
                                                              : r_s1_beat.meta;
    assign w_hdr_next    = r_cfg_le ? {w_hdr_val, r_hdr[OUT_WIDTH-1:16]}
                                    : {r_hdr[OUT_WIDTH-17:0], w_hdr_val};
    assign w_hdr_done    = (r_hdr_slot == HSW'(HS - 1));
    assign w_hdr_pending = (r_hdr_slot != '0);

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state          <= ST_STREAM;
            r_cfg_image_type <= '0;
            r_cfg_mode       <= '0;
            r_cfg_le         <= 1'b0;
            r_acc            <= '0;
            r_fill           <= '0;
            r_phase          <= 1'b0;
            r_u0             <= '0;
            r_v0             <= '0;
            r_hdr            <= '0;
            r_hdr_slot       <= '0;
            r_hdr_idx        <= '0;
            r_dvo            <= 1'b0;
            r_dtypeo         <= '0;
            r_datao          <= '0;
            r_err            <= 1'b0;
        end else begin
            r_dvo    <= 1'b0;
            r_dtypeo <= '0;
            r_datao  <= '0;
            case (r_state)
                // Flush word went out last cycle; FRAME_END follows and any new beat is lost.
                ST_FLUSH: begin
                    r_dvo    <= 1'b1;
                    r_dtypeo <= DTYPE_FRAME_END;
                    r_state  <= ST_END;
                    if (r_s1_dv) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_STREAM;
                    if (r_s1_dv && !w_is_hdr && w_hdr_pending) begin
                        r_err      <= 1'b1;
                        r_hdr_slot <= '0;
                    end
                    if (w_is_pixel) begin
                        r_phase <= ~r_phase;
                        if (!r_phase) begin
                            r_u0 <= r_s1_beat.u;
                            r_v0 <= r_s1_beat.v;
                        end
                        if (w_emit) begin
                            r_dvo    <= 1'b1;
                            r_dtypeo <= DTYPE_PIXEL;
                            r_datao  <= w_word;
                            r_acc    <= w_acc_push << OUT_WIDTH;
                            r_fill   <= w_fill_push - FW'(OUT_WIDTH);
                        end else begin
                            r_acc  <= w_acc_push;
                            r_fill <= w_fill_push;
                        end
                    end else if (w_is_hdr) begin
                        r_hdr     <= w_hdr_next;
                        r_hdr_idx <= r_hdr_idx + 16'd1;
                        if (w_hdr_done) begin
                            r_dvo      <= 1'b1;
                            r_dtypeo   <= DTYPE_HEADER;
                            r_datao    <= w_hdr_next;
                            r_hdr_slot <= '0;
                        end else begin
                            r_hdr_slot <= r_hdr_slot + HSW'(1);
                        end
                    end else if (r_s1_dv) begin
                        r_dvo    <= 1'b1;
                        r_dtypeo <= r_s1_beat.dtype;
                        case (r_s1_beat.dtype)
                            DTYPE_FRAME_START: begin
                                r_cfg_image_type <= r_s1_image_type;
                                r_cfg_mode       <= r_s1_mode;
                                r_cfg_le         <= r_s1_le;
                                r_err            <= 1'b0;
                                r_acc            <= '0;
                                r_fill           <= '0;
                                r_hdr_slot       <= '0;
                                r_hdr_idx        <= '0;
                            end
                            DTYPE_HEADER_START: begin
                                r_acc      <= '0;
                                r_fill     <= '0;
                                r_hdr_slot <= '0;
                                r_hdr_idx  <= '0;
                            end
                            DTYPE_ROW_START: r_phase <= 1'b0;
                            DTYPE_FRAME_END: begin
                                if (r_fill != '0) begin
                                    r_dtypeo <= DTYPE_PIXEL;
                                    r_datao  <= w_flush_word;
                                    r_acc    <= '0;
                                    r_fill   <= '0;
                                    r_state  <= ST_FLUSH;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign dvo    = r_dvo;
    assign dtypeo = r_dtypeo;
    assign datao  = r_datao;
    assign err    = r_err;

endmodule
